e_alu_mdu: RTL and testbench

- Parametrised execute-stage ALU with an integrated iterative multiply/divide unit (MDU) and architectural HI/LO registers.
- Single-cycle ops (logic, add/sub, shifts, compares, lui, link) are combinational, as in the current E-stage ALU.
- Multiply, divide and HI/LO moves run through a sequential FSM. A stall output holds the pipeline while the MDU is busy.
- Sits in the E stage between the ID/EX register and the EX/MEM register; the hazard unit consumes the stall output.

---
 rtl/e_alu_pkg.sv | 45 ++++
 rtl/e_mdu_iter.sv | 147 ++++++++++++++
 rtl/e_alu_mdu.sv | 74 +++++++
 tb/tb_e_alu_mdu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e_alu_pkg.sv
// Shared types for the execute-stage ALU and its iterative multiply/divide unit.
package e_alu_pkg;

  typedef enum logic [4:0] {
    OpAnd   = 5'd0,
    OpOr    = 5'd1,
    OpAdd   = 5'd2,
    OpSll   = 5'd3,
    OpSrl   = 5'd4,
    OpSra   = 5'd5,
    OpSub   = 5'd6,
    OpSlt   = 5'd7,
    OpLui   = 5'd8,
    OpLink  = 5'd9,
    OpSltu  = 5'd10,
    OpNor   = 5'd12,
    OpXor   = 5'd13,
    OpMult  = 5'd16,
    OpMultu = 5'd17,
    OpDiv   = 5'd18,
    OpDivu  = 5'd19,
    OpMfhi  = 5'd20,
    OpMflo  = 5'd21,
    OpMthi  = 5'd22,
    OpMtlo  = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } mdu_state_e;

  // Codes 16..23: anything that touches the MDU or HI/LO.
  function automatic logic is_mdu_op(input logic [4:0] code);
    return (code[4:3] == 2'b10);
  endfunction

  // Codes 16..19: multiply/divide that start an iterative operation.
  function automatic logic is_mdu_start(input logic [4:0] code);
    return (code[4:2] == 3'b100);
  endfunction

endpackage

// File: rtl/e_mdu_iter.sv
// Iterative multiply/divide FSM: one bit per cycle shift-add multiply and restoring
// divide on magnitudes, sign fix-up in a final cycle, and the architectural HI/LO.
module e_mdu_iter
  import e_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            valid_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  mdu_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                dzero_q, dzero_d;
  logic                is_div_q, is_div_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  logic                signed_op;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo, rem;

  assign signed_op = (op_i == OpMult) || (op_i == OpDiv);
  assign a_mag     = (signed_op && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag     = (signed_op && b_i[XLEN-1]) ? -b_i : b_i;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign prod_fix  = qneg_q ? -acc_q : acc_q;
  assign quo       = acc_q[XLEN-1:0];
  assign rem       = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dzero_d  = dzero_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (is_mdu_start(op_i)) begin
            state_d  = op_i[1] ? DIV : MUL;
            cnt_d    = CntW'(XLEN);
            opb_d    = b_mag;
            acc_d    = {{XLEN{1'b0}}, a_mag};
            qneg_d   = signed_op && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            rneg_d   = signed_op && a_i[XLEN-1];
            dzero_d  = (b_i == '0);
            is_div_d = op_i[1];
          end else if (op_i == OpMthi) begin
            hi_d = a_i;
          end else if (op_i == OpMtlo) begin
            lo_d = a_i;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = FIX;
      end
      DIV: begin
        // A zero divisor never fails the trial subtract, giving an all-ones quotient.
        if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          lo_d = dzero_q ? '1 : (qneg_q ? -quo : quo);
          hi_d = rneg_q ? -rem : rem;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over completion: abandon the op and leave HI/LO untouched.
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dzero_q  <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dzero_q  <= dzero_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/e_alu_mdu.sv
// Execute-stage ALU: combinational single-cycle ops plus the iterative MDU, with a
// stall that holds only MDU/HI-LO instructions while the MDU is busy.
module e_alu_mdu
  import e_alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN),
  parameter int unsigned CTRL_W  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [XLEN-1:0]    i_data_A,
  input  logic [XLEN-1:0]    i_data_B,
  input  logic [SHAMT_W-1:0] i_data_shamt,
  input  logic [CTRL_W-1:0]  i_con_AluCtrl,
  input  logic               i_con_valid,
  input  logic               i_con_flush,
  output logic [XLEN-1:0]    o_data_AluRes,
  output logic               o_con_stall,
  output logic               o_con_busy
);

  localparam logic [XLEN-1:0] LinkOff = XLEN'(4);

  logic [4:0]      code;
  logic [XLEN-1:0] hi, lo;
  logic            busy;
  logic [XLEN-1:0] alu_res;

  assign code = 5'(i_con_AluCtrl);

  e_mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .op_i   (code),
    .a_i    (i_data_A),
    .b_i    (i_data_B),
    .valid_i(i_con_valid),
    .flush_i(i_con_flush),
    .hi_o   (hi),
    .lo_o   (lo),
    .busy_o (busy)
  );

  always_comb begin
    alu_res = '0;
    case (code)
      OpAnd:  alu_res = i_data_A & i_data_B;
      OpOr:   alu_res = i_data_A | i_data_B;
      OpAdd:  alu_res = i_data_A + i_data_B;
      OpSll:  alu_res = i_data_B << i_data_shamt;
      OpSrl:  alu_res = i_data_B >> i_data_shamt;
      OpSra:  alu_res = $signed(i_data_B) >>> i_data_shamt;
      OpSub:  alu_res = i_data_A - i_data_B;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_data_A) < $signed(i_data_B))};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, (i_data_A < i_data_B)};
      OpLui:  alu_res = {i_data_B[XLEN/2-1:0], {(XLEN/2){1'b0}}};
      OpLink: alu_res = i_data_A + LinkOff;
      OpNor:  alu_res = ~(i_data_A | i_data_B);
      OpXor:  alu_res = i_data_A ^ i_data_B;
      OpMfhi: alu_res = hi;
      OpMflo: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  assign o_data_AluRes = alu_res;
  assign o_con_busy    = busy;
  // The accepting instruction sees busy=0, so it leaves E without stalling.
  assign o_con_stall   = i_con_valid && busy && is_mdu_op(code);

endmodule

// File: tb/tb_e_alu_mdu.sv
// Directed bench for e_alu_mdu (XLEN=32): single-cycle ops, MDU results and timing,
// stall behaviour, flush and asynchronous reset.
module tb_e_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [4:0]  shamt, ctrl;
  logic        valid, flush;
  logic [31:0] res;
  logic        stall, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  logic [31:0] hi_v, lo_v;

  always #5 clk = ~clk;

  e_alu_mdu #(
    .XLEN   (32),
    .SHAMT_W(5),
    .CTRL_W (5)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_A     (a),
    .i_data_B     (b),
    .i_data_shamt (shamt),
    .i_con_AluCtrl(ctrl),
    .i_con_valid  (valid),
    .i_con_flush  (flush),
    .o_data_AluRes(res),
    .o_con_stall  (stall),
    .o_con_busy   (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                     input logic [4:0] sh, input string tag, input logic [31:0] exp);
    ctrl = op; a = av; b = bv; shamt = sh; valid = 1'b1;
    #1;
    check_eq(tag, res, exp);
  endtask

  task automatic read_hilo(output logic [31:0] hv, output logic [31:0] lv);
    valid = 1'b1;
    ctrl = 5'd20; #1; hv = res;
    ctrl = 5'd21; #1; lv = res;
    valid = 1'b0; ctrl = 5'd0;
  endtask

  // Issue one MDU op and count the cycles busy stays high after the accept edge.
  task automatic mdu_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int n);
    @(negedge clk);
    ctrl = op; a = av; b = bv; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; ctrl = 5'd0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; shamt = '0; ctrl = 5'd16; valid = 1'b1; flush = 1'b0;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    read_hilo(hi_v, lo_v);
    check_eq("rst_hi", hi_v, 32'd0);
    check_eq("rst_lo", lo_v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle operations
    @(negedge clk);
    alu(5'd5,  32'h0, 32'h80000000, 5'd4, "sra", 32'hF8000000);
    alu(5'd4,  32'h0, 32'h80000000, 5'd4, "srl", 32'h08000000);
    alu(5'd3,  32'h0, 32'h00000003, 5'd31, "sll", 32'h80000000);
    alu(5'd7,  32'hFFFFFFFF, 32'h1, 5'd0, "slt", 32'h1);
    alu(5'd10, 32'hFFFFFFFF, 32'h1, 5'd0, "sltu", 32'h0);
    alu(5'd2,  32'hFFFFFFFF, 32'h2, 5'd0, "add_wrap", 32'h1);
    alu(5'd6,  32'h5, 32'h7, 5'd0, "sub", 32'hFFFFFFFE);
    alu(5'd8,  32'h0, 32'h1234ABCD, 5'd0, "lui", 32'hABCD0000);
    alu(5'd9,  32'h100, 32'h0, 5'd0, "link", 32'h104);
    alu(5'd12, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, "nor", 32'h00000F0F);
    alu(5'd13, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, "xor", 32'hF0F0F0F0);
    alu(5'd11, 32'h5, 32'h5, 5'd0, "undef", 32'h0);
    valid = 1'b0;

    // Multiply / divide results
    mdu_op(5'd16, 32'hFFFFFFFE, 32'h3, cyc);
    check_eq("mult_busy_cycles", 32'(cyc), 32'd33);
    read_hilo(hi_v, lo_v);
    check_eq("mult_hi", hi_v, 32'hFFFFFFFF);
    check_eq("mult_lo", lo_v, 32'hFFFFFFFA);

    mdu_op(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    read_hilo(hi_v, lo_v);
    check_eq("multu_hi", hi_v, 32'hFFFFFFFE);
    check_eq("multu_lo", lo_v, 32'h00000001);

    mdu_op(5'd18, 32'hFFFFFFF9, 32'h2, cyc);
    read_hilo(hi_v, lo_v);
    check_eq("div_hi", hi_v, 32'hFFFFFFFF);
    check_eq("div_lo", lo_v, 32'hFFFFFFFD);

    mdu_op(5'd19, 32'h7, 32'h0, cyc);
    read_hilo(hi_v, lo_v);
    check_eq("divu0_hi", hi_v, 32'h7);
    check_eq("divu0_lo", lo_v, 32'hFFFFFFFF);

    mdu_op(5'd18, 32'hFFFFFFF9, 32'h0, cyc);
    read_hilo(hi_v, lo_v);
    check_eq("div0_hi", hi_v, 32'hFFFFFFF9);
    check_eq("div0_lo", lo_v, 32'hFFFFFFFF);

    mdu_op(5'd18, 32'h80000000, 32'hFFFFFFFF, cyc);
    read_hilo(hi_v, lo_v);
    check_eq("divovf_hi", hi_v, 32'h0);
    check_eq("divovf_lo", lo_v, 32'h80000000);

    // MFLO one cycle behind a MULT stalls; an ADD in between flows
    @(negedge clk);
    ctrl = 5'd16; a = 32'd5; b = 32'd6; valid = 1'b1;
    #1;
    check_eq("accept_nostall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    ctrl = 5'd2; a = 32'd100; b = 32'd23;
    #1;
    check_eq("add_busy_stall", 32'(stall), 32'd0);
    check_eq("add_busy_res", res, 32'd123);
    @(posedge clk);
    #1;
    ctrl = 5'd21;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
    end
    check_eq("mflo_stall_cycles", 32'(cyc), 32'd32);
    check_eq("mflo_after", res, 32'd30);
    valid = 1'b0;

    // Flush mid-DIV, then a MULT accepted right away
    @(negedge clk);
    ctrl = 5'd18; a = 32'd100; b = 32'd7; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; ctrl = 5'd0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_eq("div_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_busy", 32'(busy), 32'd0);
    read_hilo(hi_v, lo_v);
    check_eq("flush_hi", hi_v, 32'd0);
    check_eq("flush_lo", lo_v, 32'd30);
    mdu_op(5'd16, 32'd7, 32'd8, cyc);
    check_eq("post_flush_cycles", 32'(cyc), 32'd33);
    read_hilo(hi_v, lo_v);
    check_eq("post_flush_lo", lo_v, 32'd56);

    // Flush in IDLE suppresses MTHI
    @(negedge clk);
    ctrl = 5'd22; a = 32'hDEAD; valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; valid = 1'b0;
    read_hilo(hi_v, lo_v);
    check_eq("flush_mthi", hi_v, 32'd0);

    // MTLO while busy stalls, then executes once idle
    @(negedge clk);
    ctrl = 5'd16; a = 32'd2; b = 32'd3; valid = 1'b1;
    @(posedge clk);
    #1;
    ctrl = 5'd23; a = 32'hABCD;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
    end
    check_eq("mtlo_stall_cycles", 32'(cyc), 32'd33);
    @(posedge clk);
    #1;
    valid = 1'b0;
    read_hilo(hi_v, lo_v);
    check_eq("mtlo_hi", hi_v, 32'd0);
    check_eq("mtlo_lo", lo_v, 32'hABCD);

    // Asynchronous reset mid-MUL
    @(negedge clk);
    ctrl = 5'd17; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; ctrl = 5'd0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    read_hilo(hi_v, lo_v);
    check_eq("arst_hi", hi_v, 32'd0);
    check_eq("arst_lo", lo_v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    ctrl = 5'd22; a = 32'h1234; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    read_hilo(hi_v, lo_v);
    check_eq("mthi_mfhi", hi_v, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
